// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Brief    : Shared state codes, error codes and timing defaults for the PS/2
//            host-side blocks.
// Revision : 1.0
// ============================================================================
package ps2_pkg;

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_inhibit = 3'd1;
    localparam logic [2:0] c_st_req     = 3'd2;
    localparam logic [2:0] c_st_shift   = 3'd3;
    localparam logic [2:0] c_st_ack     = 3'd4;
    localparam logic [2:0] c_st_done    = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = c_st_idle,
        INHIBIT = c_st_inhibit,
        REQ     = c_st_req,
        SHIFT   = c_st_shift,
        ACK     = c_st_ack,
        DONE    = c_st_done
    } tx_state_t;

    localparam logic [1:0] PS2_ACK     = 2'b00;
    localparam logic [1:0] PS2_NACK    = 2'b01;
    localparam logic [1:0] PS2_TIMEOUT = 2'b10;

    localparam int PS2_INHIBIT_DEF = 240;
    localparam int PS2_TIMEOUT_DEF = 30000;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_host_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx_if
// Brief    : Command handshake, status and open-drain pin bundle of the PS/2
//            host transmitter.
// Revision : 1.0
// ============================================================================
interface ps2_host_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic [1:0] err;

    modport master (
        output tx_data, tx_valid, ps2_clk_in, ps2_data_in,
        input  tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, err
    );

    modport slave (
        input  tx_data, tx_valid, ps2_clk_in, ps2_data_in,
        output tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, err
    );

endinterface
`default_nettype wire

// File: rtl/ps2_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : ps2_sync_edge
// Brief    : Two-flop synchronizer for a PS/2 clock/data pair plus a registered
//            clock falling-edge strobe.
// Revision : 1.0
// ============================================================================
module ps2_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_ps2_clk,
    input  logic i_ps2_data,
    output logic o_data_s,
    output logic o_fall
);

    logic [1:0] r_clk_sync;
    logic [1:0] r_data_sync;
    logic       r_clk_prev;
    logic       r_fall;

    // Idle bus level is high, so reset to 1 to avoid a spurious edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_prev  <= 1'b1;
            r_fall      <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
            r_data_sync <= {r_data_sync[0], i_ps2_data};
            r_clk_prev  <= r_clk_sync[1];
            r_fall      <= r_clk_prev & ~r_clk_sync[1];
        end
    end

    assign o_data_s = r_data_sync[1];
    assign o_fall   = r_fall;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Brief    : PS/2 host-to-device command transmitter with line-level ACK and
//            clock timeout reporting.
// Revision : 1.0
// ============================================================================
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_DEF,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    ps2_host_tx_if.slave  bus
);

    localparam int c_inh_w = $clog2(INHIBIT_CYCLES + 1);
    localparam int c_tmo_w = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_inh_w-1:0] c_inh_last = c_inh_w'(INHIBIT_CYCLES - 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);

    tx_state_t          r_state;
    logic [9:0]         r_frame;
    logic [3:0]         r_bit_cnt;
    logic [c_inh_w-1:0] r_inh_cnt;
    logic [c_tmo_w-1:0] r_tmo_cnt;
    logic               r_clk_oe;
    logic               r_data_oe;
    logic [1:0]         r_err;

    logic w_data_s;
    logic w_fall;
    logic w_tmo;

    ps2_sync_edge u_sync (
        .clk        (clk),
        .reset      (reset),
        .i_ps2_clk  (bus.ps2_clk_in),
        .i_ps2_data (bus.ps2_data_in),
        .o_data_s   (w_data_s),
        .o_fall     (w_fall)
    );

    assign w_tmo = (r_tmo_cnt == c_tmo_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_frame   <= '0;
            r_bit_cnt <= '0;
            r_inh_cnt <= '0;
            r_tmo_cnt <= '0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_err     <= PS2_ACK;
        end else begin
            case (r_state)
                IDLE: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    if (bus.tx_valid) begin
                        // Frame shifts out LSB first: D0..D7, parity, stop.
                        r_frame   <= {1'b1, odd_parity(bus.tx_data), bus.tx_data};
                        r_bit_cnt <= '0;
                        r_inh_cnt <= '0;
                        r_err     <= PS2_ACK;
                        r_state   <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    r_clk_oe <= 1'b1;
                    if (r_inh_cnt == c_inh_last) begin
                        r_state <= REQ;
                    end else begin
                        r_inh_cnt <= r_inh_cnt + 1'b1;
                    end
                end
                REQ: begin
                    r_clk_oe  <= 1'b1;
                    r_data_oe <= 1'b1;
                    r_tmo_cnt <= '0;
                    r_state   <= SHIFT;
                end
                SHIFT: begin
                    r_clk_oe <= 1'b0;
                    if (w_fall) begin
                        r_data_oe <= ~r_frame[0];
                        r_frame   <= {1'b1, r_frame[9:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_tmo_cnt <= '0;
                        if (r_bit_cnt == 4'd9) begin
                            r_state <= ACK;
                        end
                    end else if (w_tmo) begin
                        r_err     <= PS2_TIMEOUT;
                        r_data_oe <= 1'b0;
                        r_state   <= DONE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                ACK: begin
                    r_clk_oe <= 1'b0;
                    if (w_fall) begin
                        r_err   <= w_data_s ? PS2_NACK : PS2_ACK;
                        r_state <= DONE;
                    end else if (w_tmo) begin
                        r_err     <= PS2_TIMEOUT;
                        r_data_oe <= 1'b0;
                        r_state   <= DONE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_ready    = (r_state == IDLE);
    assign bus.busy        = (r_state != IDLE);
    assign bus.done        = (r_state == DONE);
    assign bus.err         = r_err;
    assign bus.ps2_clk_oe  = r_clk_oe;
    assign bus.ps2_data_oe = r_data_oe;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_host_tx
// Brief    : Self-checking bench for ps2_host_tx with a behavioural PS/2 device.
// Revision : 1.0
// ============================================================================
module tb_ps2_host_tx;

    localparam int M_ACK    = 0;
    localparam int M_NACK   = 1;
    localparam int M_SILENT = 2;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .INHIBIT_CYCLES (240),
        .TIMEOUT_CYCLES (30000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Open-drain wired-AND of host and device drivers.
    logic dev_clk, dev_data, dev_active, dev_abort;
    int   dev_mode, dev_half;
    logic dev_bits[$];
    assign bus.ps2_clk_in  = ~bus.ps2_clk_oe  & dev_clk;
    assign bus.ps2_data_in = ~bus.ps2_data_oe & dev_data;

    int n_tests = 0;
    int n_fail  = 0;

    int inh_cnt, done_cnt, start_cnt, rdy_viol;
    int clk_rise_cyc, clk_fall_cyc, data_rise_cyc;
    logic p_clk_oe = 1'b0, p_data_oe = 1'b0, p_busy = 1'b0;

    always @(posedge clk) begin
        #2;
        if (bus.ps2_clk_oe && !p_clk_oe) clk_rise_cyc = cyc;
        if (!bus.ps2_clk_oe && p_clk_oe) clk_fall_cyc = cyc;
        if (bus.ps2_data_oe && !p_data_oe && bus.ps2_clk_oe) data_rise_cyc = cyc;
        if (bus.ps2_clk_oe && !bus.ps2_data_oe) inh_cnt++;
        if (bus.done) done_cnt++;
        if (bus.busy && !p_busy) start_cnt++;
        if (bus.tx_ready === bus.busy) rdy_viol++;
        p_clk_oe  = bus.ps2_clk_oe;
        p_data_oe = bus.ps2_data_oe;
        p_busy    = bus.busy;
    end

    // Device: waits for the request, then clocks 11 pulses, reading the data
    // line while the clock is high and pulling data low for the ACK pulse.
    initial begin : device_model
        dev_clk = 1'b1; dev_data = 1'b1; dev_active = 1'b0;
        forever begin
            @(negedge clk);
            if (dev_mode != M_SILENT && !bus.ps2_clk_oe && bus.ps2_data_oe) begin
                dev_active = 1'b1;
                repeat (40) @(negedge clk);
                for (int k = 1; k <= 11 && !dev_abort; k++) begin
                    if (k == 11 && dev_mode == M_ACK) begin
                        dev_data = 1'b0;
                        repeat (20) @(negedge clk);
                    end
                    dev_clk = 1'b0;
                    repeat (dev_half) @(negedge clk);
                    dev_clk = 1'b1;
                    if (k <= 10) dev_bits.push_back(bus.ps2_data_in);
                    repeat (dev_half) @(negedge clk);
                    dev_data = 1'b1;
                end
                dev_active = 1'b0;
            end
        end
    end

    // Reference frame: data LSB first, odd parity bit, released stop bit.
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, b};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int acc_cyc;

    task automatic start_tx(input logic [7:0] b, input string tag);
        int w;
        @(negedge clk);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        w = 0;
        while (!bus.tx_ready && w < 100) begin @(negedge clk); w++; end
        check({tag, " accepted"}, {31'd0, bus.tx_ready}, 32'd1);
        acc_cyc = cyc + 1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'($urandom);
    endtask

    task automatic xfer(input logic [7:0] b, input int mode, input bit inject, input string tag);
        logic [9:0] fr;
        logic [1:0] exp_err;
        int w;
        bit ok;
        fr = frame_of(b);
        exp_err = (mode == M_ACK) ? 2'b00 : (mode == M_NACK) ? 2'b01 : 2'b10;
        dev_mode = mode;
        dev_half = int'($urandom_range(60, 100));
        dev_bits.delete();
        inh_cnt = 0; done_cnt = 0; start_cnt = 0; rdy_viol = 0;
        start_tx(b, tag);
        if (inject) begin
            w = 0;
            while (dev_bits.size() < 3 && w < 5000) begin @(negedge clk); w++; end
            bus.tx_data  = 8'h55;
            bus.tx_valid = 1'b1;
            @(negedge clk);
            bus.tx_valid = 1'b0;
        end
        ok = 1'b0;
        w  = 0;
        while (!ok && w < 40000) begin
            @(negedge clk);
            if (bus.done) ok = 1'b1;
            w++;
        end
        check({tag, " done seen"}, {31'd0, ok}, 32'd1);
        check({tag, " err"}, {30'd0, bus.err}, {30'd0, exp_err});
        if (mode == M_SILENT) check({tag, " timeout latency"}, cyc - data_rise_cyc, 30000);
        @(negedge clk);
        check({tag, " done one cycle"}, {31'd0, bus.done}, 32'd0);
        check({tag, " ready after"}, {31'd0, bus.tx_ready}, 32'd1);
        check({tag, " lines released"}, {30'd0, bus.ps2_clk_oe, bus.ps2_data_oe}, 32'd0);
        check({tag, " err held"}, {30'd0, bus.err}, {30'd0, exp_err});
        w = 0;
        while (dev_active && w < 1000) begin @(negedge clk); w++; end
        if (mode != M_SILENT) begin
            check({tag, " bit count"}, dev_bits.size(), 10);
            for (int k = 0; k < 10 && k < dev_bits.size(); k++)
                check($sformatf("%s bit%0d", tag, k), {31'd0, dev_bits[k]}, {31'd0, fr[k]});
        end else begin
            check({tag, " no device bits"}, dev_bits.size(), 0);
        end
        check({tag, " single start"}, start_cnt, 1);
        check({tag, " single done"}, done_cnt, 1);
        check({tag, " inhibit length"}, inh_cnt, 240);
        check({tag, " ready/busy"}, rdy_viol, 0);
    endtask

    initial begin : main
        logic [7:0] fix_bits;
        int w;
        reset = 1'b1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        dev_mode = M_ACK; dev_abort = 1'b0; dev_half = 80;
        repeat (3) @(negedge clk);
        check("reset clk_oe",   {31'd0, bus.ps2_clk_oe},  32'd0);
        check("reset data_oe",  {31'd0, bus.ps2_data_oe}, 32'd0);
        check("reset tx_ready", {31'd0, bus.tx_ready},    32'd1);
        check("reset busy",     {31'd0, bus.busy},        32'd0);
        check("reset done",     {31'd0, bus.done},        32'd0);
        check("reset err",      {30'd0, bus.err},         32'd0);
        reset = 1'b0;

        // 0xF4: data levels 0,0,1,0,1,1,1,1 then parity 0, stop 1.
        xfer(8'hF4, M_ACK, 1'b0, "f4");
        fix_bits = 8'hF4;
        for (int k = 0; k < 8 && k < dev_bits.size(); k++)
            check($sformatf("f4 fixed bit%0d", k), {31'd0, dev_bits[k]}, {31'd0, fix_bits[k]});
        check("f4 clk_oe rise",  clk_rise_cyc,  acc_cyc + 1);
        check("f4 data_oe rise", data_rise_cyc, acc_cyc + 241);
        check("f4 clk_oe fall",  clk_fall_cyc,  acc_cyc + 242);

        xfer(8'hED, M_ACK,    1'b0, "ed");
        xfer(8'h3C, M_NACK,   1'b0, "nack");
        xfer(8'hF4, M_SILENT, 1'b0, "timeout");

        // Reset part-way through a transfer.
        dev_mode = M_ACK;
        dev_half = 80;
        dev_bits.delete();
        done_cnt = 0;
        start_tx(8'hF4, "rst");
        w = 0;
        while (dev_bits.size() < 4 && w < 5000) begin @(negedge clk); w++; end
        check("rst reached bit4", {31'd0, dev_bits.size() >= 4}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst lines released", {30'd0, bus.ps2_clk_oe, bus.ps2_data_oe}, 32'd0);
        check("rst tx_ready", {31'd0, bus.tx_ready}, 32'd1);
        reset = 1'b0;
        dev_abort = 1'b1;
        w = 0;
        while (dev_active && w < 1000) begin @(negedge clk); w++; end
        dev_abort = 1'b0;
        repeat (20) @(negedge clk);
        check("rst no done", done_cnt, 0);
        check("rst idle ready", {31'd0, bus.tx_ready}, 32'd1);

        xfer(8'hF4, M_ACK, 1'b0, "post-rst");
        xfer(8'hF4, M_ACK, 1'b1, "inject55");

        for (int i = 0; i < 3; i++)
            xfer(8'($urandom), int'($urandom_range(0, 1)), 1'b0, $sformatf("rand%0d", i));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
